cu_mc: RTL

- Parametrised multi-cycle control unit, next generation of the single-cycle-execute CPU controller.
- Decodes the instruction register and drives the datapath control word: PC select, register select, ALU function, bus muxes, memory and IO strobes.
- New over the previous generation:
  - parametrised register-address width;
  - memory/IO ready handshake with wait states;
  - counter-driven multi-bit shift (XXL);
  - BRN tests the N flag;
  - resumable halt;
  - illegal-opcode flag.

---
 rtl/cu_mc.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/cu_mc.sv
// Multi-cycle CPU control unit. It decodes the instruction register and drives
// the datapath control word. It supports memory/IO wait states, a counter-driven
// multi-bit shift (XXL), a resumable halt and flagging of undecoded opcodes.

package mycpu_pkg;
  typedef enum logic [6:0] {
    OP_MOVA = 7'h00, OP_INC  = 7'h01, OP_ADD  = 7'h02, OP_SUB  = 7'h05,
    OP_DEC  = 7'h06, OP_AND  = 7'h08, OP_OR   = 7'h09, OP_XOR  = 7'h0A,
    OP_NOT  = 7'h0B, OP_MOVB = 7'h0C, OP_SHR  = 7'h0D, OP_SHL  = 7'h0E,
    OP_CLR  = 7'h0F, OP_LD   = 7'h10, OP_IOR  = 7'h11, OP_ST   = 7'h20,
    OP_IOW  = 7'h21, OP_XXL  = 7'h3E, OP_ADI  = 7'h42, OP_LDI  = 7'h4C,
    OP_BRZ  = 7'h60, OP_BRN  = 7'h61, OP_JMP  = 7'h70, OP_HAL  = 7'h7E
  } opcode_t;
endpackage

module cu_mc
  import mycpu_pkg::*;
#(
  parameter int IW  = 16,
  parameter int RAW = 3,
  parameter int SCW = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [IW-1:0]        ins_in,
  input  logic                 z_in,
  input  logic                 n_in,
  input  logic                 rdy_in,
  input  logic                 resume_in,
  output logic                 il_out,
  output logic [1:0]           ps_out,
  output logic                 rw_out,
  output logic [3*(RAW+1)-1:0] rs_out,
  output logic                 mm_out,
  output logic [1:0]           md_out,
  output logic                 mb_out,
  output logic [3:0]           fs_out,
  output logic                 wen_out,
  output logic                 iom_out,
  output logic                 req_out,
  output logic                 halted_out,
  output logic                 illegal_out
);

  typedef enum logic [2:0] {S_RST, S_INF, S_EX0, S_WAIT, S_SHF, S_HLT} state_t;

  state_t                 state;
  logic [SCW-1:0]         cnt;
  opcode_t                opc;
  logic [SCW-1:0]         count;
  logic [3*(RAW+1)-1:0]   rs_sel;
  logic                   is_rd;
  logic                   is_wr;
  logic                   is_io;

  assign opc    = opcode_t'(ins_in[IW-1:IW-7]);
  assign count  = ins_in[SCW-1:0];
  assign rs_sel = {1'b0, ins_in[3*RAW-1:2*RAW], 1'b0, ins_in[2*RAW-1:RAW],
                   1'b0, ins_in[RAW-1:0]};
  // Memory/IO transaction classes, shared by EX0 and WAIT.
  assign is_rd  = (opc == OP_LD) || (opc == OP_IOR);
  assign is_wr  = (opc == OP_ST) || (opc == OP_IOW);
  assign is_io  = (opc == OP_IOR) || (opc == OP_IOW);

  // State sequencing and XXL shift counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_RST;
      cnt   <= '0;
    end else begin
      case (state)
        S_RST: state <= S_INF;
        S_INF: state <= S_EX0;
        S_EX0: begin
          if (is_rd || is_wr) begin
            state <= rdy_in ? S_INF : S_WAIT;
          end else if (opc == OP_XXL) begin
            if (count == '0) begin
              state <= S_INF;
            end else begin
              cnt   <= count;
              state <= S_SHF;
            end
          end else if (opc == OP_HAL) begin
            state <= S_HLT;
          end else begin
            state <= S_INF;
          end
        end
        S_WAIT: if (rdy_in) state <= S_INF;
        S_SHF: begin
          cnt <= cnt - SCW'(1);
          if (cnt == SCW'(1)) state <= S_INF;
        end
        S_HLT: if (resume_in) state <= S_INF;
        default: state <= S_RST;
      endcase
    end
  end

  // Control word: idle values first, then overridden per state and opcode.
  always_comb begin
    il_out      = 1'b0;
    ps_out      = 2'b00;
    rw_out      = 1'b0;
    rs_out      = '0;
    mm_out      = 1'b0;
    md_out      = 2'b00;
    mb_out      = 1'b0;
    fs_out      = 4'b0000;
    wen_out     = 1'b1;
    iom_out     = 1'b0;
    req_out     = 1'b0;
    halted_out  = 1'b0;
    illegal_out = 1'b0;
    case (state)
      S_INF: il_out = 1'b1;
      S_EX0: begin
        rs_out = rs_sel;
        fs_out = ins_in[IW-4:IW-7];
        case (opc)
          OP_MOVA, OP_INC, OP_ADD, OP_SUB, OP_DEC, OP_AND, OP_OR, OP_XOR,
          OP_NOT, OP_MOVB, OP_SHR, OP_SHL, OP_CLR: begin
            rw_out = 1'b1;
            ps_out = 2'b01;
          end
          OP_LDI, OP_ADI: begin
            rw_out = 1'b1;
            ps_out = 2'b01;
            mb_out = 1'b1;
          end
          OP_LD, OP_IOR, OP_ST, OP_IOW: begin
            req_out = 1'b1;
            iom_out = is_io;
            wen_out = !is_wr;
            md_out  = (opc == OP_LD) ? 2'b01 : 2'b00;
            if (rdy_in) begin
              rw_out = is_rd;
              ps_out = 2'b01;
            end
          end
          OP_BRZ: ps_out = z_in ? 2'b10 : 2'b01;
          OP_BRN: ps_out = n_in ? 2'b10 : 2'b01;
          OP_JMP: ps_out = 2'b11;
          OP_XXL: ps_out = (count == '0) ? 2'b01 : 2'b00;
          OP_HAL: ps_out = 2'b01;
          default: begin
            rs_out      = '0;
            fs_out      = 4'b0000;
            illegal_out = 1'b1;
            ps_out      = 2'b01;
          end
        endcase
      end
      S_WAIT: begin
        // The IR is frozen here (il=0), so the decode still describes the
        // outstanding transaction.
        rs_out  = rs_sel;
        req_out = 1'b1;
        iom_out = is_io;
        wen_out = !is_wr;
        md_out  = (opc == OP_LD) ? 2'b01 : 2'b00;
        if (rdy_in) begin
          rw_out = is_rd;
          ps_out = 2'b01;
        end
      end
      S_SHF: begin
        rw_out = 1'b1;
        fs_out = 4'b1110;
        rs_out = rs_sel;
        if (cnt == SCW'(1)) ps_out = 2'b01;
      end
      S_HLT: halted_out = 1'b1;
      default: ;
    endcase
  end

endmodule
